pmod_oled_demo: RTL and testbench
=================================

// Module: pmod_oled_demo
// PURPOSE
//  Stand-alone power-up, init and demo driver for a Digilent PmodOLED (SSD1306, 128x32) on the FPGA board.
//  - Sequences VDD/RES/VBAT, sends the SSD1306 init list over a write-only SPI link, then streams a test pattern forever.
//  - Sits beside the MNIST core in the board top; no data interface to it. The RGB LEDs show progress.
// PARAMETERS
//  CLK_HZ     12_000_000  input clock frequency; 1 ms tick = CLK_HZ/1000 cycles
//  SPI_DIV    6           clk cycles per SCLK half-period (12 MHz -> 1 MHz SCLK)
//  T_VDD_MS   1           delay after VDD on, before reset pulse
//  T_RES_MS   1           RES low time, and also the settle time after RES high
//  T_VBAT_MS  100         delay after VBAT on, before display-on command
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  led_red_n  out  1  0 while power/init is in progress
//  led_blu_n  out  1  0 once pattern streaming has started
//  sclk       out  1  SPI clock, idles high
//  mosi       out  1  SPI data, MSB first
//  cs         out  1  chip select, active-low
//  dc         out  1  0 = command byte, 1 = display data byte
//  res        out  1  OLED reset, active-low
//  vbatc      out  1  VBAT enable, active-low
//  vddc       out  1  VDD enable, active-low
// BEHAVIOUR
//  Reset values (async on rst=1; reset mid-operation restarts the whole sequence from PWR_VDD):
//   sclk=1, mosi=0, cs=1, dc=0, res=1, vbatc=1, vddc=1, led_red_n=1, led_blu_n=1.
//  FSM states, in order:
//   1. PWR_VDD: vddc=0, led_red_n=0; wait T_VDD_MS.
//   2. RES_LO: res=0 for T_RES_MS.
//   3. RES_HI: res=1 for T_RES_MS.
//   4. INIT: send with dc=0: AE D5 80 A8 1F D3 00 40 8D 14 20 00 A1 C8 DA 02 81 8F D9 F1 DB 40 A4 A6 21 00 7F 22 00 03.
//   5. VBAT: vbatc=0; wait T_VBAT_MS.
//   6. ON: send AF with dc=0.
//   7. STREAM: led_red_n=1, led_blu_n=0; send data bytes with dc=1 forever.
//      - Column counter c runs 0..127 and page counter p runs 0..3, column fastest; both wrap (512 bytes per frame).
//      - The SSD1306 horizontal addressing wraps by itself, so no re-addressing between frames.
//  vddc, vbatc and res, once asserted, stay asserted until rst.
//  SPI byte transfer:
//   - dc is stable >= SPI_DIV clk before cs falls.
//   - cs low, then 8 bits MSB first, each bit 2*SPI_DIV clk long: mosi changes while sclk=0 (low half first); sclk rises at mid-bit.
//   - After bit 0, sclk returns high and cs rises; cs stays high >= SPI_DIV clk before the next byte.
//   - Each byte therefore takes 16*SPI_DIV clk + 2*SPI_DIV clk of guard time.
//  Pattern byte: (c[3] ^ p[0]) ? 8'h0F : 8'hF0, a checkerboard of 8-column blocks.
//  Delay counter is 32 bit; an N ms wait is exactly N*CLK_HZ/1000 clk cycles (+/-1).
// CONFIGURATION
//  PMOD_OLED_ANIM_EN:
//   - Defined: an 8-bit frame counter f increments after each 512-byte frame (wraps 255->0), and the pattern uses (c+f) in place of c, scrolling one column per frame.
//   - Undefined: static pattern; the frame counter is not synthesized.
// TESTING
//  Use CLK_HZ=12_000, SPI_DIV=2 (1 ms = 12 clk).
//  1. rst pulse mid-STREAM -> every output returns to its reset value immediately; vddc falls 1 clk after rst release.
//  2. Power sequence: vddc falls; res falls T_VDD later (12 clk) and stays low 12 clk; the first cs fall comes >= 12 clk after res rises.
//  3. SPI decode, sampling mosi on sclk rise: first 30 bytes with dc=0 match the INIT list exactly, first byte = 0xAE.
//  4. VBAT: vbatc falls after the last INIT byte (0x03); 0xAF is sent >= 1200 clk later; led_red_n=1 and led_blu_n=0 afterwards.
//  5. Stream, static: bytes 0..7 = F0, bytes 8..15 = 0F, byte 128 = 0F; byte 512 equals byte 0; dc=1 throughout.
//  6. With PMOD_OLED_ANIM_EN: byte 512 equals byte 1 of frame 0 (F0), and byte 519 = 0F.

Source files
------------

// File: rtl/pmod_oled_demo.sv
`default_nettype none
// ============================================================================
// Module   : pmod_oled_demo
// Purpose  : Stand-alone power-up, init and demo driver for a Digilent
//            PmodOLED (SSD1306, 128x32). Sequences VDD / RES / VBAT, sends
//            the SSD1306 init list over a write-only SPI link, then streams
//            a checkerboard test pattern forever.
// Ports    : clk        system clock
//            rst        asynchronous reset, active-high
//            led_red_n  0 while power/init is in progress
//            led_blu_n  0 once pattern streaming has started
//            sclk       SPI clock, idles high
//            mosi       SPI data, MSB first
//            cs         chip select, active-low
//            dc         0 = command byte, 1 = display data byte
//            res        OLED reset, active-low
//            vbatc      VBAT enable, active-low
//            vddc       VDD enable, active-low
// Config   : PMOD_OLED_ANIM_EN - when defined, an 8-bit frame counter
//            scrolls the pattern by one column per 512-byte frame.
// Revision : 1.0 - initial release
// ============================================================================
module pmod_oled_demo #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int SPI_DIV   = 6,
  parameter int T_VDD_MS  = 1,
  parameter int T_RES_MS  = 1,
  parameter int T_VBAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  output logic led_red_n,
  output logic led_blu_n,
  output logic sclk,
  output logic mosi,
  output logic cs,
  output logic dc,
  output logic res,
  output logic vbatc,
  output logic vddc
);

  // Delay lengths in clk cycles (N ms = N*CLK_HZ/1000)
  localparam logic [31:0] c_vdd_cyc  = 32'(64'(T_VDD_MS)  * 64'(CLK_HZ) / 64'd1000);
  localparam logic [31:0] c_res_cyc  = 32'(64'(T_RES_MS)  * 64'(CLK_HZ) / 64'd1000);
  localparam logic [31:0] c_vbat_cyc = 32'(64'(T_VBAT_MS) * 64'(CLK_HZ) / 64'd1000);

  localparam int               c_div_w    = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SPI_DIV - 1);
  // Byte steps: 0 = dc setup, 1..16 = bit halves (odd = sclk low), 17 = guard
  localparam logic [4:0]       c_last_step = 5'd17;
  localparam logic [4:0]       c_init_len  = 5'd30;

  typedef enum logic [2:0] {
    S_PWR_VDD = 3'd0,
    S_RES_LO  = 3'd1,
    S_RES_HI  = 3'd2,
    S_INIT    = 3'd3,
    S_VBAT    = 3'd4,
    S_ON      = 3'd5,
    S_STREAM  = 3'd6
  } state_t;

  state_t              state_q;
  logic [31:0]         dly_q;
  logic [4:0]          idx_q;
  logic                busy_q;
  logic [c_div_w-1:0]  div_q;
  logic [4:0]          step_q;
  logic [7:0]          shreg_q;
  logic [6:0]          col_q;
  logic [1:0]          page_q;

  logic sclk_q, mosi_q, cs_q, dc_q, res_q, vbatc_q, vddc_q, led_red_n_q, led_blu_n_q;

  logic       spi_done;
  logic       spi_idle;
  logic       col_bit3;
  logic [7:0] pat_byte;

  function automatic logic [7:0] f_init_byte(input logic [4:0] i);
    case (i)
      5'd0:  f_init_byte = 8'hAE;
      5'd1:  f_init_byte = 8'hD5;
      5'd2:  f_init_byte = 8'h80;
      5'd3:  f_init_byte = 8'hA8;
      5'd4:  f_init_byte = 8'h1F;
      5'd5:  f_init_byte = 8'hD3;
      5'd6:  f_init_byte = 8'h00;
      5'd7:  f_init_byte = 8'h40;
      5'd8:  f_init_byte = 8'h8D;
      5'd9:  f_init_byte = 8'h14;
      5'd10: f_init_byte = 8'h20;
      5'd11: f_init_byte = 8'h00;
      5'd12: f_init_byte = 8'hA1;
      5'd13: f_init_byte = 8'hC8;
      5'd14: f_init_byte = 8'hDA;
      5'd15: f_init_byte = 8'h02;
      5'd16: f_init_byte = 8'h81;
      5'd17: f_init_byte = 8'h8F;
      5'd18: f_init_byte = 8'hD9;
      5'd19: f_init_byte = 8'hF1;
      5'd20: f_init_byte = 8'hDB;
      5'd21: f_init_byte = 8'h40;
      5'd22: f_init_byte = 8'hA4;
      5'd23: f_init_byte = 8'hA6;
      5'd24: f_init_byte = 8'h21;
      5'd25: f_init_byte = 8'h00;
      5'd26: f_init_byte = 8'h7F;
      5'd27: f_init_byte = 8'h22;
      5'd28: f_init_byte = 8'h00;
      5'd29: f_init_byte = 8'h03;
      default: f_init_byte = 8'h00;
    endcase
  endfunction

`ifdef PMOD_OLED_ANIM_EN
  logic [7:0] frame_q;
  // Bit 3 of (c + f) only depends on the low nibbles: c[3] ^ f[3] ^ carry from bit 2
  assign col_bit3 = col_q[3] ^ frame_q[3] ^
                    (({1'b0, col_q[2:0]} + {1'b0, frame_q[2:0]}) >= 4'd8);
`else
  assign col_bit3 = col_q[3];
`endif

  assign pat_byte = (col_bit3 ^ page_q[0]) ? 8'h0F : 8'hF0;

  // The engine can accept a new byte on the same edge the previous one ends
  assign spi_done = busy_q && (step_q == c_last_step) && (div_q == c_div_last);
  assign spi_idle = !busy_q || spi_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWR_VDD;
      dly_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      div_q       <= '0;
      step_q      <= '0;
      shreg_q     <= '0;
      col_q       <= '0;
      page_q      <= '0;
`ifdef PMOD_OLED_ANIM_EN
      frame_q     <= '0;
`endif
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cs_q        <= 1'b1;
      dc_q        <= 1'b0;
      res_q       <= 1'b1;
      vbatc_q     <= 1'b1;
      vddc_q      <= 1'b1;
      led_red_n_q <= 1'b1;
      led_blu_n_q <= 1'b1;
    end else begin
      // SPI byte engine: advances one step every SPI_DIV clocks
      if (busy_q) begin
        if (div_q == c_div_last) begin
          div_q <= '0;
          if (step_q == c_last_step) begin
            busy_q <= 1'b0;
          end else begin
            step_q <= step_q + 5'd1;
            if (step_q == c_last_step - 5'd1) begin
              sclk_q <= 1'b1;
              cs_q   <= 1'b1;
            end else if (!step_q[0]) begin
              // entering an odd step: low half of a bit, present next bit
              cs_q   <= 1'b0;
              sclk_q <= 1'b0;
              mosi_q <= shreg_q[7];
            end else begin
              // entering an even step: rising edge at mid-bit
              sclk_q  <= 1'b1;
              shreg_q <= {shreg_q[6:0], 1'b0};
            end
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
      end

      case (state_q)
        S_PWR_VDD: begin
          // First cycle only switches VDD on; the wait is counted afterwards
          if (vddc_q) begin
            vddc_q      <= 1'b0;
            led_red_n_q <= 1'b0;
            dly_q       <= '0;
          end else if (dly_q == c_vdd_cyc - 32'd1) begin
            dly_q   <= '0;
            res_q   <= 1'b0;
            state_q <= S_RES_LO;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        S_RES_LO: begin
          if (dly_q == c_res_cyc - 32'd1) begin
            dly_q   <= '0;
            res_q   <= 1'b1;
            state_q <= S_RES_HI;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        S_RES_HI: begin
          if (dly_q == c_res_cyc - 32'd1) begin
            dly_q   <= '0;
            state_q <= S_INIT;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        S_INIT: begin
          if (spi_idle) begin
            if (idx_q != c_init_len) begin
              busy_q  <= 1'b1;
              step_q  <= '0;
              div_q   <= '0;
              shreg_q <= f_init_byte(idx_q);
              dc_q    <= 1'b0;
              idx_q   <= idx_q + 5'd1;
            end else begin
              vbatc_q <= 1'b0;
              dly_q   <= '0;
              state_q <= S_VBAT;
            end
          end
        end
        S_VBAT: begin
          if (dly_q == c_vbat_cyc - 32'd1) begin
            dly_q   <= '0;
            busy_q  <= 1'b1;
            step_q  <= '0;
            div_q   <= '0;
            shreg_q <= 8'hAF;
            dc_q    <= 1'b0;
            state_q <= S_ON;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        S_ON: begin
          if (spi_idle) begin
            led_red_n_q <= 1'b1;
            led_blu_n_q <= 1'b0;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (spi_idle) begin
            busy_q  <= 1'b1;
            step_q  <= '0;
            div_q   <= '0;
            shreg_q <= pat_byte;
            dc_q    <= 1'b1;
            col_q   <= col_q + 7'd1;
            if (col_q == 7'd127) begin
              page_q <= page_q + 2'd1;
`ifdef PMOD_OLED_ANIM_EN
              if (page_q == 2'd3) begin
                frame_q <= frame_q + 8'd1;
              end
`endif
            end
          end
        end
        default: state_q <= S_PWR_VDD;
      endcase
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs        = cs_q;
  assign dc        = dc_q;
  assign res       = res_q;
  assign vbatc     = vbatc_q;
  assign vddc      = vddc_q;
  assign led_red_n = led_red_n_q;
  assign led_blu_n = led_blu_n_q;

endmodule
`default_nettype wire

// File: tb/tb_pmod_oled_demo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmod_oled_demo
// Purpose  : Self-checking bench for pmod_oled_demo. Decodes the SPI link,
//            times the power pins and compares against a reference model of
//            the init list and the checkerboard pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmod_oled_demo;

  localparam int c_ms   = 12;     // 1 ms at CLK_HZ = 12_000
  localparam int c_div  = 2;
  localparam int c_base = 31;     // index of first stream byte (30 init + AF)

  logic clk, rst;
  logic led_red_n, led_blu_n, sclk, mosi, cs, dc, res, vbatc, vddc;

  int checks = 0;
  int errors = 0;

  pmod_oled_demo #(
    .CLK_HZ(12_000), .SPI_DIV(c_div), .T_VDD_MS(1), .T_RES_MS(1), .T_VBAT_MS(100)
  ) dut (
    .clk(clk), .rst(rst),
    .led_red_n(led_red_n), .led_blu_n(led_blu_n),
    .sclk(sclk), .mosi(mosi), .cs(cs), .dc(dc),
    .res(res), .vbatc(vbatc), .vddc(vddc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] init_exp [30] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  // Reference pattern: byte n of the stream, computed from column/page/frame
  function automatic logic [7:0] model_byte(input int n);
    int c, p, col;
    c = n % 128;
    p = (n / 128) % 4;
`ifdef PMOD_OLED_ANIM_EN
    col = (c + ((n / 512) % 256)) % 128;
`else
    col = c;
`endif
    return (((col / 8) % 2) != (p % 2)) ? 8'h0F : 8'hF0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus monitor (samples on falling clk edge) ----------------
  int         cyc = 0;
  logic [7:0] q_byte [$];
  bit         q_dc   [$];
  int         q_tf   [$];
  int         q_tr   [$];
  int t_vddc_fall, t_res_fall, t_res_rise, t_vbatc_fall, t_cs_rise, t_dc_chg;
  int min_gap, min_setup, res_falls, bitcnt;
  bit dc_unstable, sticky_bad, cur_dc;
  logic [7:0] sh;
  int cur_tf;
  logic p_vddc, p_res, p_vbatc, p_cs, p_sclk, p_dc;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q_byte.delete(); q_dc.delete(); q_tf.delete(); q_tr.delete();
        t_vddc_fall = -1; t_res_fall = -1; t_res_rise = -1; t_vbatc_fall = -1;
        t_cs_rise = -100000; t_dc_chg = -100000;
        min_gap = 1000000; min_setup = 1000000; res_falls = 0; bitcnt = 0;
        dc_unstable = 0; sticky_bad = 0; sh = 8'h00; cur_dc = 0; cur_tf = 0;
      end else begin
        if (p_vddc && !vddc) t_vddc_fall = cyc;
        if (!p_vddc && vddc) sticky_bad = 1;
        if (p_vbatc && !vbatc) t_vbatc_fall = cyc;
        if (!p_vbatc && vbatc) sticky_bad = 1;
        if (p_res && !res) begin t_res_fall = cyc; res_falls++; end
        if (!p_res && res) t_res_rise = cyc;
        if (res_falls > 1) sticky_bad = 1;
        if (dc != p_dc) t_dc_chg = cyc;
        if (p_cs && !cs) begin
          bitcnt = 0; cur_dc = dc; cur_tf = cyc;
          if (cyc - t_cs_rise < min_gap) min_gap = cyc - t_cs_rise;
          if (cyc - t_dc_chg < min_setup) min_setup = cyc - t_dc_chg;
        end
        if (!cs && dc != cur_dc) dc_unstable = 1;
        if (!cs && !p_sclk && sclk) begin
          sh = {sh[6:0], mosi};
          bitcnt++;
        end
        if (!p_cs && cs) begin
          t_cs_rise = cyc;
          if (bitcnt == 8) begin
            q_byte.push_back(sh); q_dc.push_back(cur_dc);
            q_tf.push_back(cur_tf); q_tr.push_back(cyc);
          end
        end
      end
      p_vddc = vddc; p_res = res; p_vbatc = vbatc; p_cs = cs; p_sclk = sclk; p_dc = dc;
    end
  end

  // ---------------- directed sequence with randomized timing ----------------
  initial begin
    int n;
    int hold;
    bit dc_ok;
    rst = 1'b1;
    hold = $urandom_range(3, 8);
    repeat (hold) @(negedge clk);
    check("reset_outputs", {sclk, mosi, cs, dc, res, vbatc, vddc, led_red_n, led_blu_n},
          9'b1_0_1_0_1_1_1_1_1);
    rst = 1'b0;
    @(negedge clk);
    check("vddc_1clk_after_release", vddc, 1'b0);
    check("led_init", {led_red_n, led_blu_n}, 2'b01);

    n = 0;
    while (q_byte.size() < c_base + 520 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("stream_bytes_collected", q_byte.size() >= c_base + 520, 1'b1);

    check("res_fall_after_vdd", t_res_fall - t_vddc_fall, c_ms);
    check("res_low_time", t_res_rise - t_res_fall, c_ms);
    check("first_cs_after_res", (q_tf[0] - t_res_rise) >= c_ms, 1'b1);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("init_byte_%0d", i), {7'd0, q_dc[i], q_byte[i]}, {16'd0, init_exp[i]});
    end
    check("vbatc_after_last_init", t_vbatc_fall > q_tr[29], 1'b1);
    check("on_cmd", {7'd0, q_dc[30], q_byte[30]}, 16'h00AF);
    check("on_delay", (q_tf[30] - t_vbatc_fall) >= 100 * c_ms, 1'b1);
    check("led_stream", {led_red_n, led_blu_n}, 2'b10);

    dc_ok = 1;
    for (int i = c_base; i < c_base + 520; i++) if (q_dc[i] !== 1'b1) dc_ok = 0;
    check("stream_dc_high", dc_ok, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stream_byte_%0d", i), q_byte[c_base + i], model_byte(i));
    end
    check("stream_byte_128", q_byte[c_base + 128], 8'h0F);
`ifdef PMOD_OLED_ANIM_EN
    check("frame1_byte0_eq_frame0_byte1", q_byte[c_base + 512], q_byte[c_base + 1]);
    check("stream_byte_519", q_byte[c_base + 519], 8'h0F);
`else
    check("frame1_byte0_eq_frame0_byte0", q_byte[c_base + 512], q_byte[c_base]);
`endif
    for (int k = 0; k < 16; k++) begin
      int i;
      i = $urandom_range(0, 519);
      check($sformatf("stream_rand_%0d", i), q_byte[c_base + i], model_byte(i));
    end
    check("dc_stable_in_byte", dc_unstable, 1'b0);
    check("cs_high_gap", min_gap >= c_div, 1'b1);
    check("dc_setup", min_setup >= c_div, 1'b1);
    check("power_pins_sticky", sticky_bad, 1'b0);

    // Reset in the middle of streaming, at a random point
    hold = $urandom_range(5, 300);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midstream_reset_outputs", {sclk, mosi, cs, dc, res, vbatc, vddc, led_red_n, led_blu_n},
          9'b1_0_1_0_1_1_1_1_1);
    hold = $urandom_range(2, 5);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    #1;
    check("vddc_held_until_edge", vddc, 1'b1);
    @(negedge clk);
    check("vddc_1clk_after_rerelease", vddc, 1'b0);
    n = 0;
    while (q_byte.size() < 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("restart_first_byte", {7'd0, q_dc[0], q_byte[0]}, 16'h00AE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
